// File: rtl/pipelined_add_sub_pkg.sv
// rtl/pipelined_add_sub_pkg.sv - shared sizing helpers for the segmented pipelined adder/subtractor
package pipelined_add_sub_pkg;

    localparam int ALU_WIDTH = 32;

    function automatic int seg_count(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    function automatic bit seg_cfg_ok(input int width, input int seg_w);
        return (seg_w >= 1) && (seg_w <= width) && ((width % seg_w) == 0);
    endfunction

endpackage

// File: rtl/add_sub_segment.sv
// rtl/add_sub_segment.sv - combinational SEG_W-bit ripple adder segment built from full-adder cells
module add_sub_segment #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SEG_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout     = c[SEG_W];
    assign c_msb_in = c[SEG_W-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined add/sub, one SEG_W-bit ripple segment per stage with valid/ready flow control
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NUM_SEG = seg_count(WIDTH, SEG_W);

    if (!seg_cfg_ok(WIDTH, SEG_W)) begin : g_cfg_check
        $error("pipelined_add_sub: WIDTH must be a positive multiple of SEG_W");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = out_ready | ~out_valid_q;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub ? 1'b1 : cin;

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
        localparam int SRC_W = WIDTH - k * SEG_W;

        logic [SRC_W-1:0]         src_a;
        logic [SRC_W-1:0]         src_b;
        logic                     src_c;
        logic                     src_v;
        logic [SEG_W-1:0]         seg_s;
        logic                     seg_cout;
        logic                     seg_cmsb;
        logic [(k+1)*SEG_W-1:0]   acc;

        if (k == 0) begin : g_src_in
            assign src_a = a;
            assign src_b = b_eff;
            assign src_c = c0;
            assign src_v = in_valid;
            assign acc   = seg_s;
        end else begin : g_src_reg
            assign src_a = g_stage[k-1].g_reg.a_q;
            assign src_b = g_stage[k-1].g_reg.b_q;
            assign src_c = g_stage[k-1].g_reg.carry_q;
            assign src_v = g_stage[k-1].g_reg.valid_q;
            assign acc   = {seg_s, g_stage[k-1].g_reg.res_q};
        end

        add_sub_segment #(
            .SEG_W(SEG_W)
        ) u_seg (
            .a        (src_a[SEG_W-1:0]),
            .b        (src_b[SEG_W-1:0]),
            .cin      (src_c),
            .s        (seg_s),
            .cout     (seg_cout),
            .c_msb_in (seg_cmsb)
        );

        // Only unconsumed operand bits travel forward; the last stage feeds the output flops.
        if (k < NUM_SEG - 1) begin : g_reg
            localparam int REM_W = SRC_W - SEG_W;

            logic                   valid_d, valid_q;
            logic                   carry_d, carry_q;
            logic [REM_W-1:0]       a_d, a_q;
            logic [REM_W-1:0]       b_d, b_q;
            logic [(k+1)*SEG_W-1:0] res_d, res_q;

            always_comb begin
                valid_d = src_v;
                carry_d = seg_cout;
                a_d     = src_a[SRC_W-1:SEG_W];
                b_d     = src_b[SRC_W-1:SEG_W];
                res_d   = acc;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                end else if (adv) begin
                    valid_q <= valid_d;
                end
                if (adv) begin
                    carry_q <= carry_d;
                    a_q     <= a_d;
                    b_q     <= b_d;
                    res_q   <= res_d;
                end
            end
        end
    end

    always_comb begin
        out_valid_d = g_stage[NUM_SEG-1].src_v;
        s_d         = s_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (g_stage[NUM_SEG-1].src_v) begin
            s_d    = g_stage[NUM_SEG-1].acc;
            cout_d = g_stage[NUM_SEG-1].seg_cout;
            ovf_d  = g_stage[NUM_SEG-1].seg_cmsb ^ g_stage[NUM_SEG-1].seg_cout;
            zero_d = ~|g_stage[NUM_SEG-1].acc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - scoreboard bench for pipelined_add_sub with an arithmetic reference model
module tb_pipelined_add_sub;

    localparam int WIDTH   = 32;
    localparam int SEG_W   = 4;
    localparam int NUM_SEG = WIDTH / SEG_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              sub;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  s;
    logic              cout;
    logic              ovf;
    logic              zero;

    pipelined_add_sub #(
        .WIDTH(WIDTH),
        .SEG_W(SEG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
        logic             zero;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   bp       = 0;
    bit   lat_mode = 1'b1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Plain integer arithmetic: unsigned range for cout, signed range for overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                   input logic isub, input logic icin);
        exp_t   e;
        longint ua, ub, ur, sa, sbv, sr;
        ua  = longint'(ia);
        ub  = longint'(ib);
        sa  = longint'($signed(ia));
        sbv = longint'($signed(ib));
        if (isub) begin
            ur     = ua - ub;
            sr     = sa - sbv;
            e.cout = (ua >= ub);
        end else begin
            ur     = ua + ub + (icin ? 64'sd1 : 64'sd0);
            sr     = sa + sbv + (icin ? 64'sd1 : 64'sd0);
            e.cout = (ur > 64'sh0000_0000_FFFF_FFFF);
        end
        e.s    = ur[WIDTH-1:0];
        e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.zero = (e.s == '0);
        e.acc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk_exp(input logic [WIDTH-1:0] es, input logic ec, input logic eo, input logic ez);
        exp_t e;
        e.s = es; e.cout = ec; e.ovf = eo; e.zero = ez; e.acc = 0; e.lat = 1'b0;
        return e;
    endfunction

    task automatic drive_ready();
        out_ready = (bp > 0) ? 1'b0 : 1'b1;
        if (bp > 0) bp--;
    endtask

    task automatic send(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic isub, input logic icin, input bit use_e, input exp_t ein);
        bit   done  = 1'b0;
        int   guard = 0;
        exp_t e;
        e = use_e ? ein : model(ia, ib, isub, icin);
        while (!done) begin
            @(negedge clk);
            drive_ready();
            in_valid = 1'b1;
            a = ia; b = ib; sub = isub; cin = icin;
            #1;
            if (in_ready) begin
                e.acc = cyc + 1;
                e.lat = lat_mode;
                sb.push_back(e);
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 100) begin
                    n_vec++; n_err++;
                    $display("FAIL accept_timeout: in_ready stuck at %b, required 1", in_ready);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_ready();
            in_valid = 1'b0;
        end
    endtask

    // Monitor: samples mid-cycle, after the driver has settled out_ready.
    initial begin : monitor
        exp_t             e;
        bit               stalled = 1'b0;
        logic [WIDTH-1:0] held_s  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                stalled = 1'b0;
            end else if (out_valid) begin
                if (stalled) check("stall_s_stable", s, held_s);
                if (out_ready) begin
                    stalled = 1'b0;
                    if (sb.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_output: got s=%h with empty scoreboard, required no out_valid", s);
                    end else begin
                        e = sb.pop_front();
                        check("s", s, e.s);
                        check("cout", {31'b0, cout}, {31'b0, e.cout});
                        check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
                        check("zero", {31'b0, zero}, {31'b0, e.zero});
                        if (e.lat) check("latency", cyc - e.acc, NUM_SEG - 1);
                    end
                end else begin
                    check("in_ready_stall", {31'b0, in_ready}, 32'd0);
                    stalled = 1'b1;
                    held_s  = s;
                end
            end
        end
    end

    initial begin : driver
        exp_t dummy;
        int   guard;
        dummy     = mk_exp('0, 1'b0, 1'b0, 1'b0);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_s", s, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b0;

        send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b1, mk_exp(32'h0000_0008, 1'b0, 1'b0, 1'b0));
        idle(12);
        send(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1, mk_exp(32'h0000_0000, 1'b1, 1'b0, 1'b1));
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, mk_exp(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, mk_exp(32'h0000_0001, 1'b1, 1'b0, 1'b0));
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0, dummy);
        send(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, dummy);
        idle(12);

        for (int i = 0; i < 20; i++)
            send($urandom, $urandom, 1'(i % 3 == 0), 1'($urandom_range(0, 1)), 1'b0, dummy);
        idle(12);

        lat_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) bp = 5;
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, dummy);
        end
        idle(3);
        bp = 5;
        idle(25);
        lat_mode = 1'b1;

        for (int i = 0; i < 4; i++)
            send($urandom, $urandom, 1'b0, 1'b0, 1'b0, dummy);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_s", s, 32'd0);
        check("flush_cout", {31'b0, cout}, 32'd0);
        check("flush_zero", {31'b0, zero}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        idle(15);

        send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0, 1'b0, dummy);
        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            idle(1);
            guard++;
        end
        if (sb.size() > 0) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
